// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with synchronous clear, clamped parallel load,
// enable-driven prescaler, and wrap or saturate behaviour at the range ends.
module updown_mod_counter #(
    parameter int N        = 4,
    parameter int MODULUS  = 2**N,
    parameter int PRESCALE = 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic         i_clock,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic         i_up_down,
    input  logic         i_load,
    input  logic [N-1:0] i_load_value,
    output logic [N-1:0] o_q,
    output logic         o_tc,
    output logic         o_wrap
);
    localparam logic [N-1:0] TOP = N'(MODULUS - 1);
    localparam int           PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [N-1:0] r_q;
    logic         r_wrap;
    logic         w_pre_last;
    logic         w_at_top;
    logic         w_at_bot;
    logic [N-1:0] w_q_step;
    logic         w_wrap_step;
    logic [N-1:0] w_load_clamped;

    generate
        if (PRESCALE > 1) begin : g_pre
            logic [PW-1:0] r_pre;

            assign w_pre_last = (r_pre == PW'(PRESCALE - 1));

            always_ff @(posedge i_clock) begin
                if (i_clear || i_load) begin
                    r_pre <= '0;
                end else if (i_enable) begin
                    r_pre <= w_pre_last ? '0 : r_pre + PW'(1);
                end
            end
        end else begin : g_no_pre
            assign w_pre_last = 1'b1;
        end
    endgenerate

    assign w_at_top       = (r_q == TOP);
    assign w_at_bot       = (r_q == '0);
    assign w_load_clamped = (i_load_value > TOP) ? TOP : i_load_value;

    // Explicit compare-and-reload at the ends so non-power-of-two moduli wrap exactly
    always_comb begin
        w_q_step    = r_q;
        w_wrap_step = 1'b0;
        if (i_up_down) begin
            if (!w_at_top) begin
                w_q_step = r_q + N'(1);
            end else if (!SATURATE) begin
                w_q_step    = '0;
                w_wrap_step = 1'b1;
            end
        end else begin
            if (!w_at_bot) begin
                w_q_step = r_q - N'(1);
            end else if (!SATURATE) begin
                w_q_step    = TOP;
                w_wrap_step = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else if (i_load) begin
            r_q    <= w_load_clamped;
            r_wrap <= 1'b0;
        end else if (i_enable && w_pre_last) begin
            r_q    <= w_q_step;
            r_wrap <= w_wrap_step;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign o_q    = r_q;
    assign o_wrap = r_wrap;
    assign o_tc   = i_up_down ? w_at_top : w_at_bot;

endmodule
